lcd_ctrl_gen2: RTL and testbench

LCD_CTRL_GEN2 -- requirements
Module: lcd_ctrl_gen2

---
 rtl/lcd_ctrl_gen2.sv | 228 ++++++++++++++++++++++
 tb/tb_lcd_ctrl_gen2.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_ctrl_gen2.sv
// rtl/lcd_ctrl_gen2.sv - image buffer controller: ROM load, 2x2 window ops, RAM write-out
module lcd_ctrl_gen2 #(
    parameter int DW    = 8,
    parameter int IMG_W = 8,
    parameter int IMG_H = 8,
    parameter int AW    = 6
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [3:0]    cmd,
    input  logic          cmd_valid,
    input  logic [DW-1:0] IROM_Q,
    output logic          IROM_rd,
    output logic [AW-1:0] IROM_A,
    output logic          IRAM_valid,
    output logic [DW-1:0] IRAM_D,
    output logic [AW-1:0] IRAM_A,
    output logic          busy,
    output logic          done
);
    localparam int N  = IMG_W * IMG_H;
    localparam int XW = $clog2(IMG_W);
    localparam int YW = $clog2(IMG_H);
    localparam logic [AW-1:0] LAST  = AW'(N - 1);
    localparam logic [XW-1:0] X_MAX = XW'(IMG_W - 2);
    localparam logic [YW-1:0] Y_MAX = YW'(IMG_H - 2);
    localparam logic [XW-1:0] X_RST = XW'(IMG_W / 2 - 1);
    localparam logic [YW-1:0] Y_RST = YW'(IMG_H / 2 - 1);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_CMD, S_EXEC, S_WRITE, S_DONE} state_t;

    state_t          state_q, state_d;
    logic [3:0]      cmd_q, cmd_d;
    logic [XW-1:0]   x_q, x_d;
    logic [YW-1:0]   y_q, y_d;
    logic            rom_rd_q, rom_rd_d;
    logic [AW-1:0]   rom_a_q, rom_a_d;
    logic            cap_vld_q;
    logic [AW-1:0]   cap_a_q;
    logic            ram_vld_q, ram_vld_d;
    logic [AW-1:0]   ram_a_q, ram_a_d, ram_a_nx;
    logic [DW-1:0]   ram_d_q, ram_d_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic [DW-1:0]   mem_q [N];

    logic [AW-1:0]   a_tl, a_tr, a_bl, a_br;
    logic [DW-1:0]   p_tl, p_tr, p_bl, p_br;
    logic [DW-1:0]   n_tl, n_tr, n_bl, n_br;
    logic [DW-1:0]   mx_t, mx_b, mx, mn_t, mn_b, mn;
    logic [DW+1:0]   sum;
    logic            win_we;

    assign a_tl = {y_q, x_q};
    assign a_tr = {y_q, x_q + XW'(1)};
    assign a_bl = {y_q + YW'(1), x_q};
    assign a_br = {y_q + YW'(1), x_q + XW'(1)};
    assign p_tl = mem_q[a_tl];
    assign p_tr = mem_q[a_tr];
    assign p_bl = mem_q[a_bl];
    assign p_br = mem_q[a_br];
    assign ram_a_nx = ram_a_q + AW'(1);

    always_ff @(posedge clk) begin
        if (!reset_n) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  state_d = S_LOAD;
            S_LOAD:  if (cap_vld_q && cap_a_q == LAST) state_d = S_CMD;
            S_CMD:   if (cmd_valid) state_d = (cmd == 4'd0) ? S_WRITE : S_EXEC;
            S_EXEC:  state_d = (cmd_q == 4'd12) ? S_LOAD : S_CMD;
            S_WRITE: if (ram_a_q == LAST) state_d = S_DONE;
            S_DONE:  state_d = S_CMD;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        rom_rd_d  = 1'b0;
        rom_a_d   = rom_a_q;
        ram_vld_d = 1'b0;
        ram_a_d   = ram_a_q;
        ram_d_d   = ram_d_q;
        busy_d    = 1'b1;
        done_d    = 1'b0;
        cmd_d     = cmd_q;
        x_d       = x_q;
        y_d       = y_q;
        case (state_q)
            S_IDLE: begin
                rom_rd_d = 1'b1;
                rom_a_d  = '0;
            end
            S_LOAD: begin
                if (rom_rd_q && rom_a_q != LAST) begin
                    rom_rd_d = 1'b1;
                    rom_a_d  = rom_a_q + AW'(1);
                end
                if (state_d == S_CMD) busy_d = 1'b0;
            end
            S_CMD: begin
                busy_d = 1'b0;
                if (cmd_valid) begin
                    busy_d = 1'b1;
                    cmd_d  = cmd;
                    if (cmd == 4'd0) begin
                        ram_vld_d = 1'b1;
                        ram_a_d   = '0;
                        ram_d_d   = mem_q[0];
                    end
                end
            end
            S_EXEC: begin
                busy_d = 1'b0;
                case (cmd_q)
                    4'd1:  if (y_q != '0)    y_d = y_q - YW'(1);
                    4'd2:  if (y_q != Y_MAX) y_d = y_q + YW'(1);
                    4'd3:  if (x_q != '0)    x_d = x_q - XW'(1);
                    4'd4:  if (x_q != X_MAX) x_d = x_q + XW'(1);
                    4'd12: begin
                        busy_d   = 1'b1;
                        rom_rd_d = 1'b1;
                        rom_a_d  = '0;
                    end
                    4'd13: begin
                        x_d = X_RST;
                        y_d = Y_RST;
                    end
                    default: ;
                endcase
            end
            S_WRITE: begin
                if (ram_a_q != LAST) begin
                    ram_vld_d = 1'b1;
                    ram_a_d   = ram_a_nx;
                    ram_d_d   = mem_q[ram_a_nx];
                end else begin
                    done_d = 1'b1;
                end
            end
            S_DONE:  busy_d = 1'b0;
            default: ;
        endcase
    end

    // Window arithmetic; sum is two bits wider so four full-scale pixels never overflow
    always_comb begin
        mx_t   = (p_tl > p_tr) ? p_tl : p_tr;
        mx_b   = (p_bl > p_br) ? p_bl : p_br;
        mx     = (mx_t > mx_b) ? mx_t : mx_b;
        mn_t   = (p_tl < p_tr) ? p_tl : p_tr;
        mn_b   = (p_bl < p_br) ? p_bl : p_br;
        mn     = (mn_t < mn_b) ? mn_t : mn_b;
        sum    = {2'b00, p_tl} + {2'b00, p_tr} + {2'b00, p_bl} + {2'b00, p_br};
        win_we = 1'b1;
        n_tl   = p_tl;
        n_tr   = p_tr;
        n_bl   = p_bl;
        n_br   = p_br;
        case (cmd_q)
            4'd5:  begin n_tl = mx; n_tr = mx; n_bl = mx; n_br = mx; end
            4'd6:  begin n_tl = mn; n_tr = mn; n_bl = mn; n_br = mn; end
            4'd7:  begin
                n_tl = sum[DW+1:2]; n_tr = sum[DW+1:2];
                n_bl = sum[DW+1:2]; n_br = sum[DW+1:2];
            end
            4'd8:  begin n_tl = p_tr; n_tr = p_br; n_br = p_bl; n_bl = p_tl; end
            4'd9:  begin n_tl = p_bl; n_bl = p_br; n_br = p_tr; n_tr = p_tl; end
            4'd10: begin n_tl = p_bl; n_tr = p_br; n_bl = p_tl; n_br = p_tr; end
            4'd11: begin n_tl = p_tr; n_tr = p_tl; n_bl = p_br; n_br = p_bl; end
            default: win_we = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cmd_q     <= '0;
            x_q       <= X_RST;
            y_q       <= Y_RST;
            rom_rd_q  <= 1'b0;
            rom_a_q   <= '0;
            cap_vld_q <= 1'b0;
            cap_a_q   <= '0;
            ram_vld_q <= 1'b0;
            ram_a_q   <= '0;
            ram_d_q   <= '0;
            busy_q    <= 1'b1;
            done_q    <= 1'b0;
        end else begin
            cmd_q     <= cmd_d;
            x_q       <= x_d;
            y_q       <= y_d;
            rom_rd_q  <= rom_rd_d;
            rom_a_q   <= rom_a_d;
            cap_vld_q <= rom_rd_q;
            cap_a_q   <= rom_a_q;
            ram_vld_q <= ram_vld_d;
            ram_a_q   <= ram_a_d;
            ram_d_q   <= ram_d_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    // ROM data trails its address by one cycle, hence the delayed capture address
    always_ff @(posedge clk) begin
        if (cap_vld_q) begin
            mem_q[cap_a_q] <= IROM_Q;
        end else if (state_q == S_EXEC && win_we) begin
            mem_q[a_tl] <= n_tl;
            mem_q[a_tr] <= n_tr;
            mem_q[a_bl] <= n_bl;
            mem_q[a_br] <= n_br;
        end
    end

    assign IROM_rd    = rom_rd_q;
    assign IROM_A     = rom_a_q;
    assign IRAM_valid = ram_vld_q;
    assign IRAM_A     = ram_a_q;
    assign IRAM_D     = ram_d_q;
    assign busy       = busy_q;
    assign done       = done_q;
endmodule

// File: tb/tb_lcd_ctrl_gen2.sv
// tb/tb_lcd_ctrl_gen2.sv - scoreboard bench for lcd_ctrl_gen2 (8x8 and 16x4 instances)
module tb_lcd_ctrl_gen2;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] cmd;
    logic       cv, sel;
    logic       cv1, rd1, wv1, busy1, done1;
    logic       cv2, rd2, wv2, busy2, done2;
    logic [7:0] q1, q2, wd1, wd2;
    logic [5:0] ra1, ra2, wa1, wa2;
    logic [7:0] rom [64];
    logic [7:0] exp_img [64];
    logic [13:0] sb [$];
    int total = 0, bad = 0, done_cnt = 0;
    int rd_cnt, busy_at, d_snap;
    logic mon_v, mon_busy, mon_done;
    logic [5:0] mon_a;
    logic [7:0] mon_d;

    always #5 clk = ~clk;

    assign cv1 = cv & ~sel;
    assign cv2 = cv & sel;
    assign mon_v    = sel ? wv2   : wv1;
    assign mon_a    = sel ? wa2   : wa1;
    assign mon_d    = sel ? wd2   : wd1;
    assign mon_busy = sel ? busy2 : busy1;
    assign mon_done = sel ? done2 : done1;

    lcd_ctrl_gen2 u_dut1 (
        .clk(clk), .reset_n(rst_n), .cmd(cmd), .cmd_valid(cv1), .IROM_Q(q1),
        .IROM_rd(rd1), .IROM_A(ra1), .IRAM_valid(wv1), .IRAM_D(wd1), .IRAM_A(wa1),
        .busy(busy1), .done(done1)
    );

    lcd_ctrl_gen2 #(.DW(8), .IMG_W(16), .IMG_H(4), .AW(6)) u_dut2 (
        .clk(clk), .reset_n(rst_n), .cmd(cmd), .cmd_valid(cv2), .IROM_Q(q2),
        .IROM_rd(rd2), .IROM_A(ra2), .IRAM_valid(wv2), .IRAM_D(wd2), .IRAM_A(wa2),
        .busy(busy2), .done(done2)
    );

    always @(posedge clk) begin
        if (rd1) q1 <= rom[ra1];
        if (rd2) q2 <= rom[ra2];
    end

    task automatic chk(input string name, input int act, input int expv);
        total++;
        if (act != expv) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, expv);
        end
    endtask

    always @(negedge clk) begin
        logic [13:0] e;
        if (rst_n && mon_v) begin
            if (sb.size() == 0) begin
                chk("unexpected_strobe", 1, 0);
            end else begin
                e = sb.pop_front();
                chk("ram_addr", int'(mon_a), int'(e[13:8]));
                chk("ram_data", int'(mon_d), int'(e[7:0]));
            end
        end
        if (rst_n && mon_done) done_cnt++;
    end

    task automatic init_exp();
        for (int k = 0; k < 64; k++) exp_img[k] = 8'(k);
    endtask

    task automatic set4(input int a0, input int a1, input int a2, input int a3,
                        input int v0, input int v1, input int v2, input int v3);
        exp_img[a0] = 8'(v0); exp_img[a1] = 8'(v1);
        exp_img[a2] = 8'(v2); exp_img[a3] = 8'(v3);
    endtask

    task automatic push_exp();
        for (int k = 0; k < 64; k++) sb.push_back({6'(k), exp_img[k]});
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (!mon_busy) return;
        end
        chk("idle_timeout", 1, 0);
    endtask

    task automatic send_cmd(input logic [3:0] c);
        wait_idle();
        cmd = c;
        cv  = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        cv  = 1'b0;
    endtask

    task automatic write_check(input string name);
        bit seen = 0;
        push_exp();
        send_cmd(4'd0);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (mon_done) begin seen = 1; break; end
        end
        chk({name, "_done_seen"}, int'(seen), 1);
        chk({name, "_queue_drained"}, sb.size(), 0);
        sb.delete();
        @(negedge clk);
        chk({name, "_done_one_cycle"}, int'(mon_done), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        sel = 0; cv = 0; cmd = 0; rst_n = 0;
        for (int k = 0; k < 64; k++) rom[k] = 8'(k);
        repeat (3) @(negedge clk);
        chk("rst_busy", int'(busy1), 1);
        chk("rst_rom_rd", int'(rd1), 0);
        chk("rst_rom_a", int'(ra1), 0);
        chk("rst_ram_valid", int'(wv1), 0);
        chk("rst_ram_a", int'(wa1), 0);
        chk("rst_ram_d", int'(wd1), 0);
        chk("rst_done", int'(done1), 0);

        rst_n = 1;
        rd_cnt = 0; busy_at = 0;
        for (int c = 1; c <= 200; c++) begin
            @(posedge clk); #1;
            if (rd1) rd_cnt++;
            if (!busy1) begin busy_at = c; break; end
        end
        chk("load_rd_cycles", rd_cnt, 64);
        chk("busy_fall_cycle", busy_at, 66);

        init_exp(); write_check("identity");

        send_cmd(4'd5);
        init_exp(); set4(27, 28, 35, 36, 36, 36, 36, 36); write_check("max_33");

        send_cmd(4'd12);
        repeat (5) send_cmd(4'd3);
        send_cmd(4'd7);
        init_exp(); set4(24, 25, 32, 33, 28, 28, 28, 28); write_check("avg_03");

        send_cmd(4'd12);
        repeat (4) send_cmd(4'd9);
        init_exp(); write_check("cw_x4");
        send_cmd(4'd8); send_cmd(4'd9);
        init_exp(); write_check("ccw_cw");

        send_cmd(4'd9);
        init_exp(); set4(24, 25, 32, 33, 32, 24, 33, 25); write_check("cw_once");
        send_cmd(4'd8);
        send_cmd(4'd10);
        init_exp(); set4(24, 25, 32, 33, 32, 33, 24, 25); write_check("swap_rows");
        send_cmd(4'd10);
        send_cmd(4'd11);
        init_exp(); set4(24, 25, 32, 33, 25, 24, 33, 32); write_check("swap_cols");
        send_cmd(4'd11);

        send_cmd(4'd3);
        send_cmd(4'd6);
        init_exp(); set4(24, 25, 32, 33, 24, 24, 24, 24); write_check("left_sat_min");

        send_cmd(4'd12);
        send_cmd(4'd13);
        send_cmd(4'd6);
        init_exp(); set4(27, 28, 35, 36, 27, 27, 27, 27); write_check("origin_restore");

        wait_idle();
        cmd = 4'd14; cv = 1'b1;
        @(posedge clk); @(negedge clk);
        cv = 1'b0;
        chk("nop_busy_high", int'(busy1), 1);
        @(negedge clk);
        chk("nop_busy_low", int'(busy1), 0);
        write_check("nop_unchanged");

        for (int k = 0; k < 64; k++) rom[k] = 8'hFF;
        send_cmd(4'd12);
        send_cmd(4'd7);
        for (int k = 0; k < 64; k++) exp_img[k] = 8'hFF;
        write_check("avg_ff");

        for (int k = 0; k < 64; k++) rom[k] = 8'(k);
        send_cmd(4'd12);
        init_exp(); push_exp();
        send_cmd(4'd0);
        begin
            bit hit = 0;
            for (int i = 0; i < 100; i++) begin
                if (wv1 && wa1 == 6'd20) begin hit = 1; break; end
                @(negedge clk);
            end
            chk("reach_addr20", int'(hit), 1);
        end
        d_snap = done_cnt;
        rst_n = 0;
        @(negedge clk);
        chk("abort_ram_valid", int'(wv1), 0);
        chk("abort_done", int'(done1), 0);
        sb.delete();
        rst_n = 1;
        @(posedge clk); #1;
        chk("reload_rd", int'(rd1), 1);
        chk("reload_rd_a", int'(ra1), 0);
        wait_idle();
        chk("abort_no_done", done_cnt, d_snap);
        init_exp(); write_check("after_abort");

        sel = 1;
        repeat (20) send_cmd(4'd4);
        repeat (5) send_cmd(4'd2);
        send_cmd(4'd5);
        init_exp(); set4(46, 47, 62, 63, 63, 63, 63, 63); write_check("w16_sat");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
